// File: rtl/traffic_countdown_ctrl.sv
// ============================================================================
// Module      : traffic_countdown_ctrl
// Description : Phase sequencer and 1 s countdown for a main/country crossing.
//               Produces both remaining-time values, blink phase and lamp drives.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_countdown_ctrl #(
    parameter int CLK_DIV = 50_000_000,
    parameter int MAIN_G  = 25,
    parameter int MAIN_Y  = 5,
    parameter int CTRY_G  = 15,
    parameter int CTRY_Y  = 5
) (
    input  logic       CLK,
    input  logic       RET,
    input  logic       EN,
    input  logic       SENSOR,
    output logic [4:0] MainNumber,
    output logic [4:0] CountryNumber,
    output logic       C,
    output logic       MG,
    output logic       MY,
    output logic       MR,
    output logic       CG,
    output logic       CY,
    output logic       CR
);

    localparam int PW = $clog2(CLK_DIV);

    localparam logic [PW-1:0] c_presc_last = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] c_presc_half = PW'(CLK_DIV / 2);
    localparam logic [4:0]    c_main_g     = 5'(MAIN_G);
    localparam logic [4:0]    c_main_y     = 5'(MAIN_Y);
    localparam logic [4:0]    c_ctry_g     = 5'(CTRY_G);
    localparam logic [4:0]    c_ctry_y     = 5'(CTRY_Y);

    // Lamp order: {MG, MY, MR, CG, CY, CR}
    localparam logic [5:0] c_lamp_mg = 6'b100_001;
    localparam logic [5:0] c_lamp_my = 6'b010_001;
    localparam logic [5:0] c_lamp_cg = 6'b001_100;
    localparam logic [5:0] c_lamp_cy = 6'b001_010;

    typedef enum logic [1:0] {
        S_MG = 2'd0,
        S_MY = 2'd1,
        S_CG = 2'd2,
        S_CY = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [4:0]      r_count;
    logic [4:0]      w_count_nxt;
    logic [4:0]      r_main;
    logic [4:0]      w_main_nxt;
    logic [4:0]      r_ctry;
    logic [4:0]      w_ctry_nxt;
    logic            r_c;
    logic            w_c_nxt;
    logic [5:0]      r_lamps;
    logic [5:0]      w_lamps_nxt;
    logic            w_tick;

    always_ff @(posedge CLK or negedge RET) begin
        if (!RET) begin
            r_state <= S_MG;
            r_presc <= '0;
            r_count <= c_main_g;
            r_main  <= c_main_g;
            r_ctry  <= 5'({1'b0, c_main_g} + {1'b0, c_main_y});
            r_c     <= 1'b1;
            r_lamps <= c_lamp_mg;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_count <= w_count_nxt;
            r_main  <= w_main_nxt;
            r_ctry  <= w_ctry_nxt;
            r_c     <= w_c_nxt;
            r_lamps <= w_lamps_nxt;
        end
    end

    always_comb begin
        w_tick      = EN && (r_presc == c_presc_last);
        w_presc_nxt = r_presc;
        w_state_nxt = r_state;
        w_count_nxt = r_count;

        if (EN) begin
            w_presc_nxt = (r_presc == c_presc_last) ? '0 : r_presc + 1'b1;
        end

        if (w_tick) begin
            if (r_count > 5'd1) begin
                w_count_nxt = 5'({1'b0, r_count} - 6'd1);
            end else begin
                case (r_state)
                    // Without a waiting car the main phase parks at count 1.
                    S_MG: begin
                        if (SENSOR) begin
                            w_state_nxt = S_MY;
                            w_count_nxt = c_main_y;
                        end
                    end
                    S_MY: begin
                        w_state_nxt = S_CG;
                        w_count_nxt = c_ctry_g;
                    end
                    S_CG: begin
                        w_state_nxt = S_CY;
                        w_count_nxt = c_ctry_y;
                    end
                    S_CY: begin
                        w_state_nxt = S_MG;
                        w_count_nxt = c_main_g;
                    end
                    default: begin
                        w_state_nxt = S_MG;
                        w_count_nxt = c_main_g;
                    end
                endcase
            end
        end

        // Outputs are derived from the next state so they register with it.
        w_main_nxt  = w_count_nxt;
        w_ctry_nxt  = w_count_nxt;
        w_lamps_nxt = c_lamp_mg;
        case (w_state_nxt)
            S_MG: begin
                w_ctry_nxt  = 5'({1'b0, w_count_nxt} + {1'b0, c_main_y});
                w_lamps_nxt = c_lamp_mg;
            end
            S_MY: w_lamps_nxt = c_lamp_my;
            S_CG: begin
                w_main_nxt  = 5'({1'b0, w_count_nxt} + {1'b0, c_ctry_y});
                w_lamps_nxt = c_lamp_cg;
            end
            S_CY: w_lamps_nxt = c_lamp_cy;
            default: w_lamps_nxt = c_lamp_mg;
        endcase

        w_c_nxt = !EN || (w_presc_nxt < c_presc_half);
    end

    assign MainNumber    = r_main;
    assign CountryNumber = r_ctry;
    assign C             = r_c;
    assign {MG, MY, MR, CG, CY, CR} = r_lamps;

    // A zero count can only come from a zero duration parameter.
    a_count_nonzero : assert property (@(posedge CLK) disable iff (!RET) r_count != 5'd0);

endmodule

`default_nettype wire

// File: tb/tb_traffic_countdown_ctrl.sv
// ============================================================================
// Module      : tb_traffic_countdown_ctrl
// Description : Scoreboard bench for traffic_countdown_ctrl with small timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traffic_countdown_ctrl;

    logic       CLK    = 1'b0;
    logic       RET    = 1'b0;
    logic       EN     = 1'b1;
    logic       SENSOR = 1'b1;
    logic [4:0] MainNumber;
    logic [4:0] CountryNumber;
    logic       C;
    logic       MG, MY, MR, CG, CY, CR;

    traffic_countdown_ctrl #(
        .CLK_DIV (4),
        .MAIN_G  (3),
        .MAIN_Y  (2),
        .CTRY_G  (2),
        .CTRY_Y  (1)
    ) u_dut (
        .CLK           (CLK),
        .RET           (RET),
        .EN            (EN),
        .SENSOR        (SENSOR),
        .MainNumber    (MainNumber),
        .CountryNumber (CountryNumber),
        .C             (C),
        .MG            (MG),
        .MY            (MY),
        .MR            (MR),
        .CG            (CG),
        .CY            (CY),
        .CR            (CR)
    );

    always #5 CLK = ~CLK;

    localparam logic [5:0] L_MG = 6'b100_001;
    localparam logic [5:0] L_MY = 6'b010_001;
    localparam logic [5:0] L_CG = 6'b001_100;
    localparam logic [5:0] L_CY = 6'b001_010;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [16:0] sb[$];
    logic [16:0] exp_v;
    wire  [16:0] obs = {MainNumber, CountryNumber, C, MG, MY, MR, CG, CY, CR};

    // Expected {main, country, C, lamps} after k run edges, SENSOR held high.
    function automatic logic [16:0] exp_at(input int k);
        logic [4:0] m, c;
        logic [5:0] l;
        case ((k / 4) % 8)
            0: begin m = 5'd3; c = 5'd5; l = L_MG; end
            1: begin m = 5'd2; c = 5'd4; l = L_MG; end
            2: begin m = 5'd1; c = 5'd3; l = L_MG; end
            3: begin m = 5'd2; c = 5'd2; l = L_MY; end
            4: begin m = 5'd1; c = 5'd1; l = L_MY; end
            5: begin m = 5'd3; c = 5'd2; l = L_CG; end
            6: begin m = 5'd2; c = 5'd1; l = L_CG; end
            default: begin m = 5'd1; c = 5'd1; l = L_CY; end
        endcase
        return {m, c, ((k % 4) < 2), l};
    endfunction

    task automatic apply_reset();
        @(posedge CLK);
        #1 RET = 1'b0;
        @(posedge CLK);
        #1 RET = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #1 RET = 1'b0;
        sb.push_back(exp_at(0));
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected %h", obs, exp_v);
        end
        sb.push_back(exp_at(0));
        @(posedge CLK);
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_held: got %h expected %h", obs, exp_v);
        end
        RET = 1'b1;
    endtask

    task automatic test_full_cycle();
        apply_reset();
        for (int k = 1; k <= 36; k++) begin
            sb.push_back(exp_at(k));
            @(posedge CLK);
            #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL cycle k=%0d: got %h expected %h", k, obs, exp_v);
            end
            vectors++;
            if (!($onehot({MG, MY, MR}) && $onehot({CG, CY, CR}))) begin
                miscompares++;
                $display("FAIL onehot k=%0d: got lamps %b expected one-hot per road", k,
                         {MG, MY, MR, CG, CY, CR});
            end
        end
    endtask

    task automatic test_sensor_hold();
        SENSOR = 1'b0;
        apply_reset();
        for (int k = 1; k <= 46; k++) begin
            if (k < 8)
                sb.push_back(exp_at(k));
            else if (k < 44)
                sb.push_back({5'd1, 5'd3, ((k % 4) < 2), L_MG});
            else
                sb.push_back({5'd2, 5'd2, ((k % 4) < 2), L_MY});
            @(posedge CLK);
            #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL sensor_hold k=%0d: got %h expected %h", k, obs, exp_v);
            end
            if (k == 40) SENSOR = 1'b1;
        end
    endtask

    task automatic test_enable_freeze();
        int kk = 0;
        apply_reset();
        for (int j = 1; j <= 18; j++) begin
            if (j == 7)  EN = 1'b0;
            if (j == 17) EN = 1'b1;
            if (EN) begin
                kk++;
                sb.push_back(exp_at(kk));
            end else begin
                sb.push_back({5'd2, 5'd4, 1'b1, L_MG});
            end
            @(posedge CLK);
            #1;
            exp_v = sb.pop_front();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL enable j=%0d: got %h expected %h", j, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_phase();
        apply_reset();
        repeat (22) @(posedge CLK);
        sb.push_back(exp_at(22));
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL mid_cg: got %h expected %h", obs, exp_v);
        end
        #1 RET = 1'b0;
        sb.push_back(exp_at(0));
        #1;
        exp_v = sb.pop_front();
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL reset_no_edge: got %h expected %h", obs, exp_v);
        end
        @(posedge CLK);
        #1 RET = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_cycle();
        test_sensor_hold();
        test_enable_freeze();
        test_reset_mid_phase();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
